sram16_dram_responder: RTL and testbench
========================================

# sram16_dram_responder

Responder end of the MCU's external DRAM request interface. It accepts one 32-bit word request at a time (read or byte-enabled write) and executes it as two 16-bit half-word cycles on an asynchronous external SRAM with programmable wait states. It returns a single-cycle `mem_ack` with read data. The block sits at the board top, between the MCU's `dram_mem_*` ports and the SRAM pins.

## Interface
Parameters:
- `WAIT_STATES`, default 2: extra strobe cycles per SRAM access (strobe width = `WAIT_STATES`+1); legal 0–15.
- `ADDR_BITS`, default `` `MEM_ADDR_BITS ``: width of the word address.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sync_reset` in 1: synchronous reset, same effect as `reset_n`.
- `mem_addr` in `ADDR_BITS`: word address.
- `mem_read_en` in 1: read request strobe.
- `mem_write_en` in 1: write request strobe.
- `mem_byte_enable` in 4: byte lanes of the write.
- `mem_write_data` in 32: write word.
- `mem_ack` out 1: one-cycle completion pulse.
- `mem_read_data` out 32: read word; valid while `mem_ack` is high and held until the next capture.
- `busy` out 1: high from the capture cycle through the ack cycle.
- `proto_err` out 1: sticky; set by a protocol violation; cleared only by reset.
- `sram_addr` out `ADDR_BITS`+1: half-word address, {`mem_addr`, half}.
- `sram_dq_in` in 16: SRAM data read.
- `sram_dq_out` out 16: SRAM data drive.
- `sram_dq_oe` out 1: tri-state enable for `sram_dq_out`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` out 1 each: active-low SRAM controls.

## Operation
- Request capture: in IDLE, a rising edge with `mem_read_en` or `mem_write_en` high latches the address, byte enables, write data and direction.
- Read and write both high: treated as a write; sets `proto_err`.
- Request strobe while `busy`: ignored; sets `proto_err`.
- States: IDLE → LO_SETUP → LO_STROBE → LO_HOLD → HI_SETUP → HI_STROBE → HI_HOLD → DONE → IDLE.
- Low half covers byte lanes [1:0] at `sram_addr` LSB = 0. High half covers lanes [3:2] at LSB = 1.
- SETUP, 1 cycle: address valid, `ce_n` = 0, `oe_n` and `we_n` high.
  - Write: `dq_oe` = 1 and data driven.
- STROBE, `WAIT_STATES`+1 cycles, counted by a 4-bit down-counter:
  - Read: `oe_n` = 0, `ub_n` = `lb_n` = 0.
  - Write: `we_n` = 0, `ub_n`/`lb_n` = inverted byte enables for that half.
- HOLD, 1 cycle: `oe_n` and `we_n` high; address, `ce_n` and write data still held.
  - Read: `sram_dq_in` is registered on the last STROBE cycle into the matching half of `mem_read_data`.
- Write half with both enables of that half 0: the phase is skipped entirely, with no SRAM activity.
- Write with `mem_byte_enable` = 0: goes IDLE → DONE directly.
- Reads always execute both halves.
- DONE: `mem_ack` = 1 for exactly one cycle, then IDLE. A new request is capturable on the edge that leaves DONE.
- Reset values of all outputs, under `reset_n` low (immediate) or `sync_reset` (next edge): state IDLE, `mem_ack` 0, `mem_read_data` 0, `busy` 0, `proto_err` 0, `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0, all `*_n` controls 1.
- Reset mid-transfer: the transfer is abandoned and no ack is issued.

## Timing
- Let the request be captured at edge k, and P = `WAIT_STATES`+3 (cycles per phase).
- Full read or full write: `ce_n` low from cycle k+1; `mem_ack` high in cycle k+1+2P. With `WAIT_STATES` = 2 that is k+11.
- Single-half write: `mem_ack` in cycle k+1+P (k+6 at default).
- Zero-enable write: `mem_ack` in cycle k+1.
- `sram_we_n` is never low in a cycle where `sram_addr` changes.
- `sram_dq_oe` is never high while `sram_oe_n` is low.
- `ce_n` deasserts for exactly 0 cycles between halves, i.e. stays low from LO_SETUP through HI_HOLD. The exception is a skipped half, where it is high.
- All outputs are registered.

## Structure
- Shared package `sram16_pkg`:
  - enum `sram16_state_t` (IDLE, LO_SETUP, LO_STROBE, LO_HOLD, HI_SETUP, HI_STROBE, HI_HOLD, DONE);
  - `SRAM_DQ_BITS` = 16;
  - `SRAM_WS_BITS` = 4.
- Single module. State register, wait counter and output registers are inline; no sub-module is warranted.
- Tri-state buffer is instantiated at the board top, not here.

## Test plan
- Read at `mem_addr` 0x0012, SRAM model returns 0xBEEF at half-address 0x24 and 0xDEAD at 0x25 → `mem_read_data` 0xDEADBEEF with `mem_ack` at k+11; `oe_n` low for 3 cycles per half.
- Write 0x12345678 with enables 0xF to 0x0004 → SRAM 0x08 = 0x5678, 0x09 = 0x1234, `ub_n`/`lb_n` both 0, `mem_ack` at k+11.
- Write with enables 0x4 → only the high half is accessed, with `ub_n` = 1, `lb_n` = 0; SRAM 0x08 is untouched; `mem_ack` at k+6. Write with enables 0x0 → `mem_ack` at k+1 and no `ce_n` activity.
- Read and write asserted together → write performed, `proto_err` = 1. A second strobe during `busy` → ignored, with exactly one ack.
- `reset_n` pulsed low during LO_STROBE → all controls go high immediately, no ack; a following read completes normally.
- `WAIT_STATES` = 0 build → full read ack at k+7; back-to-back reads issued on each DONE edge produce consecutive acks 7 cycles apart.

Source files
------------

// File: rtl/sram16_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif

package sram16_pkg;

    localparam int SRAM_DQ_BITS = 16;
    localparam int SRAM_WS_BITS = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LO_SETUP  = 3'd1,
        LO_STROBE = 3'd2,
        LO_HOLD   = 3'd3,
        HI_SETUP  = 3'd4,
        HI_STROBE = 3'd5,
        HI_HOLD   = 3'd6,
        DONE      = 3'd7
    } sram16_state_t;

    // True when the state drives the upper half-word (sram_addr LSB = 1).
    function automatic logic is_hi_phase(input sram16_state_t s);
        return (s == HI_SETUP) || (s == HI_STROBE) || (s == HI_HOLD);
    endfunction

    // True in any state that owns the SRAM bus (chip enable asserted).
    function automatic logic is_active(input sram16_state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/sram16_dram_responder.sv
// Executes one 32-bit word read/write as two 16-bit SRAM cycles (setup, strobe, hold).
// Latency: ack 2*(WAIT_STATES+3)+1 cycles after capture for a full word, less for skipped write halves.
// Backpressure: one request in flight; strobes while busy are dropped and flag proto_err.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif

module sram16_dram_responder
    import sram16_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_BITS   = `MEM_ADDR_BITS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sync_reset,
    input  logic [ADDR_BITS-1:0]    mem_addr,
    input  logic                    mem_read_en,
    input  logic                    mem_write_en,
    input  logic [3:0]              mem_byte_enable,
    input  logic [31:0]             mem_write_data,
    output logic                    mem_ack,
    output logic [31:0]             mem_read_data,
    output logic                    busy,
    output logic                    proto_err,
    output logic [ADDR_BITS:0]      sram_addr,
    input  logic [SRAM_DQ_BITS-1:0] sram_dq_in,
    output logic [SRAM_DQ_BITS-1:0] sram_dq_out,
    output logic                    sram_dq_oe,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n,
    output logic                    sram_ub_n,
    output logic                    sram_lb_n
);

    localparam logic [SRAM_WS_BITS-1:0] WS_LOAD = SRAM_WS_BITS'(WAIT_STATES);

    sram16_state_t           state_q, state_d;
    logic [SRAM_WS_BITS-1:0] cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [3:0]              be_q, be_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    wr_q, wr_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    perr_q, perr_d;

    logic                    ack_q, ack_d;
    logic                    busy_q, busy_d;
    logic [ADDR_BITS:0]      sram_addr_q, sram_addr_d;
    logic [SRAM_DQ_BITS-1:0] dq_out_q, dq_out_d;
    logic                    dq_oe_q, dq_oe_d;
    logic                    ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                    ub_n_q, ub_n_d, lb_n_q, lb_n_d;

    logic req;
    logic hi_d, strobe_d;

    assign req = mem_read_en | mem_write_en;

    // Sequencer: request capture, phase walk, skipped write halves, read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        perr_d  = perr_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (req) begin
                    addr_d  = mem_addr;
                    be_d    = mem_byte_enable;
                    wdata_d = mem_write_data;
                    // A simultaneous read+write strobe resolves to a write.
                    wr_d    = mem_write_en;
                    if (mem_read_en && mem_write_en) perr_d = 1'b1;
                    if (!mem_write_en || (mem_byte_enable[1:0] != 2'b00)) state_d = LO_SETUP;
                    else if (mem_byte_enable[3:2] != 2'b00)               state_d = HI_SETUP;
                    else                                                  state_d = DONE;
                end
            end
            LO_SETUP: begin
                state_d = LO_STROBE;
                cnt_d   = WS_LOAD;
            end
            LO_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = LO_HOLD;
                    if (!wr_q) rdata_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LO_HOLD: state_d = (!wr_q || (be_q[3:2] != 2'b00)) ? HI_SETUP : DONE;
            HI_SETUP: begin
                state_d = HI_STROBE;
                cnt_d   = WS_LOAD;
            end
            HI_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HI_HOLD;
                    if (!wr_q) rdata_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HI_HOLD: state_d = DONE;
            default: state_d = IDLE;
        endcase
        // DONE accepts a new request, so only the SRAM-owning states count as busy here.
        if (req && is_active(state_q)) perr_d = 1'b1;
    end

    // Output decode from the next state so every pin is a flop aligned with its state.
    always_comb begin
        hi_d        = is_hi_phase(state_d);
        strobe_d    = (state_d == LO_STROBE) || (state_d == HI_STROBE);
        ack_d       = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        if (is_active(state_d)) begin
            sram_addr_d = {addr_d, hi_d};
            ce_n_d      = 1'b0;
            if (wr_d) begin
                dq_oe_d  = 1'b1;
                dq_out_d = hi_d ? wdata_d[31:16] : wdata_d[15:0];
            end
            if (strobe_d) begin
                if (wr_d) begin
                    we_n_d           = 1'b0;
                    {ub_n_d, lb_n_d} = hi_d ? ~be_d[3:2] : ~be_d[1:0];
                end else begin
                    oe_n_d = 1'b0;
                    ub_n_d = 1'b0;
                    lb_n_d = 1'b0;
                end
            end
        end
    end

    // Sequencer and request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else if (sync_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    // Registered bus-side and handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            {ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q} <= 5'b11111;
        end else if (sync_reset) begin
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            {ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q} <= 5'b11111;
        end else begin
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            {ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q} <= {ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d};
        end
    end

    assign mem_ack       = ack_q;
    assign mem_read_data = rdata_q;
    assign busy          = busy_q;
    assign proto_err     = perr_q;
    assign sram_addr     = sram_addr_q;
    assign sram_dq_out   = dq_out_q;
    assign sram_dq_oe    = dq_oe_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_ub_n     = ub_n_q;
    assign sram_lb_n     = lb_n_q;

endmodule

// File: tb/tb_sram16_dram_responder.sv
module tb_sram16_dram_responder;

    localparam int AB = 12;
    localparam int SA = AB + 1;
    localparam int P  = 5;          // cycles per phase at WAIT_STATES = 2

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance 0: WAIT_STATES = 2 ----------------
    logic          reset_n, sync_reset;
    logic [AB-1:0] mem_addr;
    logic          mem_read_en, mem_write_en;
    logic [3:0]    mem_byte_enable;
    logic [31:0]   mem_write_data;
    logic          mem_ack, busy, proto_err;
    logic [31:0]   mem_read_data;
    logic [SA-1:0] sram_addr;
    logic [15:0]   sram_dq_in, sram_dq_out;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    sram16_dram_responder #(.WAIT_STATES(2), .ADDR_BITS(AB)) u0 (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
        .mem_ack(mem_ack), .mem_read_data(mem_read_data), .busy(busy), .proto_err(proto_err),
        .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    // ---------------- instance 1: WAIT_STATES = 0 ----------------
    logic          u1_sync_reset, u1_rd, u1_wr;
    logic [AB-1:0] u1_addr;
    logic [3:0]    u1_be;
    logic [31:0]   u1_wdata, u1_rdata;
    logic          u1_ack, u1_busy, u1_perr;
    logic [SA-1:0] u1_sram_addr;
    logic [15:0]   u1_dq_in, u1_dq_out;
    logic          u1_dq_oe, u1_ce_n, u1_oe_n, u1_we_n, u1_ub_n, u1_lb_n;

    sram16_dram_responder #(.WAIT_STATES(0), .ADDR_BITS(AB)) u1 (
        .clk(clk), .reset_n(reset_n), .sync_reset(u1_sync_reset),
        .mem_addr(u1_addr), .mem_read_en(u1_rd), .mem_write_en(u1_wr),
        .mem_byte_enable(u1_be), .mem_write_data(u1_wdata),
        .mem_ack(u1_ack), .mem_read_data(u1_rdata), .busy(u1_busy), .proto_err(u1_perr),
        .sram_addr(u1_sram_addr), .sram_dq_in(u1_dq_in), .sram_dq_out(u1_dq_out),
        .sram_dq_oe(u1_dq_oe), .sram_ce_n(u1_ce_n), .sram_oe_n(u1_oe_n),
        .sram_we_n(u1_we_n), .sram_ub_n(u1_ub_n), .sram_lb_n(u1_lb_n)
    );

    function automatic logic [15:0] pat(input logic [SA-1:0] a);
        logic [15:0] x;
        x = 16'(a);
        return (x * 16'h1357) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] init_val(input logic [SA-1:0] a);
        if (a == SA'(13'h24)) return 16'hBEEF;
        if (a == SA'(13'h25)) return 16'hDEAD;
        return pat(a) ^ 16'h0F0F;
    endfunction

    // Instance 1 sees a read-only SRAM whose contents are a pure function of address.
    assign u1_dq_in = (!u1_ce_n && !u1_oe_n) ? pat(u1_sram_addr) : 16'hF00D;

    // ---------------- SRAM model and pin monitor for instance 0 ----------------
    logic [15:0]   sram [0:(1<<SA)-1];
    bit            init_done = 1'b0;
    int            ack_count = 0, last_ack_cyc = 0, ce_low = 0, oe_low = 0, viol = 0;
    logic [31:0]   last_ack_data = '0;
    logic          last_ub = 1'b1, last_lb = 1'b1;
    logic [SA-1:0] prev_addr = '0;

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr] : 16'hF00D;

    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < (1 << SA); i++) sram[i] = init_val(SA'(i));
            init_done = 1'b1;
        end
        if (mem_ack) begin
            ack_count++;
            last_ack_cyc  = cyc;
            last_ack_data = mem_read_data;
        end
        if (!sram_ce_n) ce_low++;
        if (!sram_oe_n) oe_low++;
        if (sram_dq_oe && !sram_oe_n) viol++;
        if (!sram_we_n && (sram_addr !== prev_addr)) viol++;
        if (!sram_ce_n && !sram_we_n) begin
            last_ub = sram_ub_n;
            last_lb = sram_lb_n;
            if (!sram_dq_oe) viol++;
            if (!sram_lb_n) sram[sram_addr][7:0]  = sram_dq_out[7:0];
            if (!sram_ub_n) sram[sram_addr][15:8] = sram_dq_out[15:8];
        end
        prev_addr = sram_addr;
    end

    // ---------------- reference model and checking ----------------
    logic [15:0] ref_mem [0:(1<<SA)-1];
    int n_err = 0, n_checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic ref_write(input logic [AB-1:0] a, input logic [3:0] be, input logic [31:0] wd);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) ref_mem[{a, b[1]}][(b%2)*8 +: 8] = wd[b*8 +: 8];
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [AB-1:0] a);
        return {ref_mem[{a, 1'b1}], ref_mem[{a, 1'b0}]};
    endfunction

    function automatic logic [31:0] sram_word(input logic [AB-1:0] a);
        return {sram[{a, 1'b1}], sram[{a, 1'b0}]};
    endfunction

    // Present a request for one capture edge; k is the capture edge number.
    task automatic issue(input bit rd, input bit wr, input logic [AB-1:0] a, input logic [3:0] be,
                         input logic [31:0] wd, output int k, output int snap, output int ce0,
                         output int oe0);
        @(negedge clk); #1;
        snap = ack_count; ce0 = ce_low; oe0 = oe_low;
        mem_read_en = rd; mem_write_en = wr; mem_addr = a;
        mem_byte_enable = be; mem_write_data = wd;
        @(posedge clk); #1;
        k = cyc;
        @(negedge clk); #1;
        mem_read_en = 1'b0; mem_write_en = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int k, input int snap, input int exp_cyc);
        int n;
        n = 0;
        while (ack_count == snap && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, " ack seen"}, 64'(ack_count - snap), 64'd1);
        check({tag, " ack cycle"}, 64'(last_ack_cyc - k + 1), 64'(exp_cyc));
    endtask

    initial begin
        int k, snap, ce0, oe0, halves, exp_cyc, prev, got_acks;
        bit rd;
        logic [AB-1:0] a;
        logic [3:0] be;
        logic [31:0] wd;

        reset_n = 1'b0; sync_reset = 1'b0;
        mem_addr = '0; mem_read_en = 1'b0; mem_write_en = 1'b0;
        mem_byte_enable = '0; mem_write_data = '0;
        u1_sync_reset = 1'b0; u1_rd = 1'b0; u1_wr = 1'b0;
        u1_addr = '0; u1_be = '0; u1_wdata = '0;
        for (int i = 0; i < (1 << SA); i++) ref_mem[i] = init_val(SA'(i));

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset ack/busy/perr/oe", {mem_ack, busy, proto_err, sram_dq_oe}, 4'b0000);
        check("reset controls", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check("reset addr/dq/rdata", {sram_addr, sram_dq_out, mem_read_data}, '0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed full read
        issue(1'b1, 1'b0, 12'h012, 4'h0, 32'h0, k, snap, ce0, oe0);
        wait_ack("read 0x12", k, snap, 11);
        check("read 0x12 data", last_ack_data, 32'hDEADBEEF);
        check("read 0x12 oe_n low cycles", 64'(oe_low - oe0), 64'd6);
        check("read 0x12 ce_n low cycles", 64'(ce_low - ce0), 64'(2 * P));

        // Directed full write
        issue(1'b0, 1'b1, 12'h004, 4'hF, 32'h12345678, k, snap, ce0, oe0);
        ref_write(12'h004, 4'hF, 32'h12345678);
        wait_ack("write full", k, snap, 11);
        check("write full sram", {sram[13'h09], sram[13'h08]}, 32'h12345678);
        check("write full ub/lb", {last_ub, last_lb}, 2'b00);

        // High-half-only write: lane 2 only
        issue(1'b0, 1'b1, 12'h004, 4'h4, 32'hAABBCCDD, k, snap, ce0, oe0);
        ref_write(12'h004, 4'h4, 32'hAABBCCDD);
        wait_ack("write be=4", k, snap, 6);
        check("write be=4 sram", {sram[13'h09], sram[13'h08]}, 32'h12BB5678);
        check("write be=4 ub/lb", {last_ub, last_lb}, 2'b10);
        check("write be=4 ce_n low cycles", 64'(ce_low - ce0), 64'(P));

        // Zero-enable write
        issue(1'b0, 1'b1, 12'h005, 4'h0, 32'hFFFFFFFF, k, snap, ce0, oe0);
        wait_ack("write be=0", k, snap, 1);
        check("write be=0 ce_n low cycles", 64'(ce_low - ce0), 64'd0);
        check("write be=0 sram", sram_word(12'h005), ref_word(12'h005));

        // Randomized traffic against the reference memory
        for (int t = 0; t < 24; t++) begin
            rd = 1'($urandom_range(0, 1));
            a  = AB'($urandom_range(64, 79));
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            halves = rd ? 2 : (int'(be[1:0] != 2'b00) + int'(be[3:2] != 2'b00));
            exp_cyc = 1 + halves * P;
            issue(rd, !rd, a, be, wd, k, snap, ce0, oe0);
            if (!rd) ref_write(a, be, wd);
            wait_ack(rd ? "rand read" : "rand write", k, snap, exp_cyc);
            if (rd) check("rand read data", last_ack_data, ref_word(a));
            else    check("rand write sram", sram_word(a), ref_word(a));
            check("rand ce_n low cycles", 64'(ce_low - ce0), 64'(halves * P));
        end
        check("perr clean traffic", proto_err, 1'b0);

        // Read and write together: performed as a write, flagged
        issue(1'b1, 1'b1, 12'h030, 4'hF, 32'hCAFEF00D, k, snap, ce0, oe0);
        ref_write(12'h030, 4'hF, 32'hCAFEF00D);
        wait_ack("rd+wr", k, snap, 11);
        check("rd+wr sram", sram_word(12'h030), 32'hCAFEF00D);
        check("rd+wr proto_err", proto_err, 1'b1);

        // Asynchronous reset during the low strobe
        issue(1'b1, 1'b0, 12'h012, 4'h0, 32'h0, k, snap, ce0, oe0);
        for (int n = 0; n < 10 && sram_oe_n; n++) begin
            @(negedge clk); #1;
        end
        check("reset test reached strobe", sram_oe_n, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("async reset controls", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check("async reset ack/busy/perr", {mem_ack, busy, proto_err}, 3'b000);
        check("async reset rdata", mem_read_data, 32'h0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("no ack after reset", 64'(ack_count - snap), 64'd0);
        issue(1'b1, 1'b0, 12'h030, 4'h0, 32'h0, k, snap, ce0, oe0);
        wait_ack("read after reset", k, snap, 11);
        check("read after reset data", last_ack_data, 32'hCAFEF00D);

        // Second strobe while busy: ignored, flagged, single ack
        issue(1'b1, 1'b0, 12'h012, 4'h0, 32'h0, k, snap, ce0, oe0);
        @(negedge clk); #1;
        mem_write_en = 1'b1; mem_addr = 12'h021; mem_byte_enable = 4'hF; mem_write_data = 32'h5555AAAA;
        @(negedge clk); #1;
        mem_write_en = 1'b0;
        wait_ack("busy strobe", k, snap, 11);
        repeat (20) @(negedge clk);
        #1;
        check("busy strobe single ack", 64'(ack_count - snap), 64'd1);
        check("busy strobe data", last_ack_data, 32'hDEADBEEF);
        check("busy strobe no write", sram_word(12'h021), ref_word(12'h021));
        check("busy strobe proto_err", proto_err, 1'b1);

        // Synchronous reset takes effect at the next edge
        sync_reset = 1'b1;
        #1;
        check("sync reset not immediate", proto_err, 1'b1);
        @(posedge clk); #1;
        check("sync reset cleared", {proto_err, busy, mem_read_data}, 34'h0);
        @(negedge clk); #1;
        sync_reset = 1'b0;

        // WAIT_STATES = 0: back-to-back reads issued on each DONE cycle
        @(negedge clk); #1;
        u1_rd = 1'b1; u1_addr = 12'h010;
        @(posedge clk); #1;
        k = cyc;
        prev = 0; got_acks = 0;
        for (int n = 0; n < 60 && got_acks < 4; n++) begin
            @(negedge clk); #1;
            u1_rd = 1'b0;
            if (u1_ack) begin
                check("ws0 read data", u1_rdata, {pat({u1_addr, 1'b1}), pat({u1_addr, 1'b0})});
                if (got_acks == 0) check("ws0 first ack cycle", 64'(cyc - k + 1), 64'd7);
                else               check("ws0 ack spacing", 64'(cyc - prev), 64'd7);
                prev = cyc;
                got_acks++;
                if (got_acks < 4) begin
                    u1_addr = u1_addr + 12'h003;
                    u1_rd   = 1'b1;
                end
            end
        end
        check("ws0 ack count", 64'(got_acks), 64'd4);

        check("pin protocol violations", 64'(viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
